// File: rtl/btn_debounce.sv
// btn_debounce: synchronizer and per-channel debouncer for asynchronous push-buttons and
// switches feeding control logic in the lclk (125 MHz) domain.
//
// Ports:
//   clk        in   lclk
//   rst        in   synchronous, active-high reset
//   din        in   raw asynchronous inputs, one bit per channel
//   level      out  debounced level
//   rise       out  one-cycle pulse when level first reads 1
//   fall       out  one-cycle pulse when level first reads 0
//   evt_latch  out  sticky flag set by rise; set wins over evt_clr
//   evt_clr    in   per-channel clear of evt_latch
//   long_press out  one-cycle pulse after level has been high for LONG_CYCLES cycles
//
// Optional feature macro: BTN_LONG_PRESS_EN. When it is undefined, long_press is tied to 0
// and no hold counters exist. When it is defined, CNT_W must be wide enough for LONG_CYCLES
// (the default CNT_W only covers DEBOUNCE_CYCLES).
module btn_debounce #(
  parameter int unsigned N_IN            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned CNT_W           = 21,
  parameter int unsigned LONG_CYCLES     = 125000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] din,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic [N_IN-1:0] evt_latch,
  input  logic [N_IN-1:0] evt_clr,
  output logic [N_IN-1:0] long_press
);

  // Parameter sanity, evaluated at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("btn_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLo,
    StChkHi,
    StHi,
    StChkLo
  } state_e;

  logic [N_IN-1:0]  meta_q;
  logic [N_IN-1:0]  sync_q;
  state_e           state_q [N_IN];
  state_e           state_d [N_IN];
  logic [CNT_W-1:0] cnt_q   [N_IN];
  logic [CNT_W-1:0] cnt_d   [N_IN];
  logic [N_IN-1:0]  level_q, level_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;
  logic [N_IN-1:0]  evt_q, evt_d;

  // Per-channel debounce FSM; a check state aborts on the first sample that disagrees.
  always_comb begin
    for (int i = 0; i < int'(N_IN); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StLo: begin
          if (sync_q[i]) begin
            state_d[i] = StChkHi;
            cnt_d[i]   = '0;
          end
        end
        StChkHi: begin
          if (!sync_q[i]) begin
            state_d[i] = StLo;
          end else if (cnt_q[i] == DbLast) begin
            state_d[i] = StHi;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        StHi: begin
          if (!sync_q[i]) begin
            state_d[i] = StChkLo;
            cnt_d[i]   = '0;
          end
        end
        StChkLo: begin
          if (sync_q[i]) begin
            state_d[i] = StHi;
          end else if (cnt_q[i] == DbLast) begin
            state_d[i] = StLo;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = StLo;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == StHi) || (state_d[i] == StChkLo);
    end
  end

  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
    // The visible rise pulse sets the flag, so a clear in that same cycle loses.
    evt_d  = rise_q | (evt_q & ~evt_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
      for (int i = 0; i < int'(N_IN); i++) begin
        state_q[i] <= StLo;
        cnt_q[i]   <= '0;
      end
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
      for (int i = 0; i < int'(N_IN); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_latch = evt_q;

`ifdef BTN_LONG_PRESS_EN
  if ((64'd1 << CNT_W) <= 64'(LONG_CYCLES)) begin : g_bad_cnt_w_long
    $error("btn_debounce: CNT_W too narrow for LONG_CYCLES");
  end

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] hold_q [N_IN];
  logic [CNT_W-1:0] hold_d [N_IN];
  logic [N_IN-1:0]  long_q, long_d;

  // hold counts cycles of level=1 since rise and parks at LongLast; the pulse fires only on
  // the step into LongLast (or on rise itself when LONG_CYCLES is 1), so one per press.
  always_comb begin
    for (int i = 0; i < int'(N_IN); i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i] || rise_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != LongLast) begin
        hold_d[i] = hold_q[i] + CNT_W'(1);
      end
      long_d[i] = level_q[i] && (hold_d[i] == LongLast) &&
                  (rise_q[i] || (hold_q[i] != LongLast));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      for (int i = 0; i < int'(N_IN); i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < int'(N_IN); i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed vector table, hand-written corner sequences
// and a randomized phase, all compared against a run-length reference model.
module tb_btn_debounce;

  localparam int unsigned N = 5;
  localparam int unsigned D = 4;
  localparam int unsigned L = 10;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] din;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] evt_latch;
  logic [N-1:0] evt_clr;
  logic [N-1:0] long_press;

  btn_debounce #(
    .N_IN           (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (W),
    .LONG_CYCLES    (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .evt_latch (evt_latch),
    .evt_clr   (evt_clr),
    .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the input seen by the debouncer is din two edges late; a channel flips
  // once it has seen D+1 consecutive samples that disagree with its current level.
  logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_evt, m_long;
  int           m_run [N];
  int           m_age [N];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] d, input logic [N-1:0] c);
    logic [N-1:0] old_lev;
    logic [N-1:0] old_rise;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_long = '0;
      for (int i = 0; i < int'(N); i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
      return;
    end
    old_lev  = m_level;
    old_rise = m_rise;
    for (int i = 0; i < int'(N); i++) begin
      if (m_s2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(D) + 1) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      // Pulse once level has been high for L full cycles since its rise.
      m_long[i] = (m_age[i] == int'(L));
      if (m_level[i]) m_age[i] = (m_age[i] < 1000) ? m_age[i] + 1 : m_age[i];
      else            m_age[i] = 0;
    end
    m_s2   = m_s1;
    m_s1   = d;
    m_rise = m_level & ~old_lev;
    m_fall = ~m_level & old_lev;
    m_evt  = old_rise | (m_evt & ~c);
  endtask

  task automatic step(input logic r, input logic [N-1:0] d, input logic [N-1:0] c);
    logic [N-1:0] exp_long;
    rst     = r;
    din     = d;
    evt_clr = c;
    @(posedge clk);
    model_edge(r, d, c);
    #1;
`ifdef BTN_LONG_PRESS_EN
    exp_long = m_long;
`else
    exp_long = '0;
`endif
    check("level", level, m_level);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("evt_latch", evt_latch, m_evt);
    check("long_press", long_press, exp_long);
    check("rise_fall_excl", rise & fall, '0);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] din;
    logic [N-1:0] clr;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] evt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int           fall_cnt;
    int           found;
    int           first_rise;
    logic [N-1:0] rise_val;
    int           long_cnt;
    int           long_first;
    logic [N-1:0] din_r;
    logic [N-1:0] clr_r;
    logic         rst_r;

    rst = 1'b1; din = '0; evt_clr = '0;
    for (int i = 0; i < int'(N); i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
    end
    m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_long = '0;

    // Row k (k >= 1) is edge k-1 counted from the first post-reset edge.
    tbl[0] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    for (int k = 1; k <= 3; k++)
      tbl[k] = '{1'b0, 5'b00011, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    for (int k = 4; k <= 6; k++)
      tbl[k] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tbl[7] = '{1'b0, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    tbl[8] = '{1'b0, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001};
    for (int k = 9; k <= 14; k++)
      tbl[k] = '{1'b0, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001};
    tbl[15] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00001};
    tbl[16] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tbl[17] = '{1'b0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

    // Directed table: ch0 press/release, ch1 3-cycle glitch, evt_clr.
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].rst, tbl[k].din, tbl[k].clr);
      check($sformatf("tbl%0d_level", k), level, tbl[k].lvl);
      check($sformatf("tbl%0d_rise", k), rise, tbl[k].rise);
      check($sformatf("tbl%0d_fall", k), fall, tbl[k].fall);
      check($sformatf("tbl%0d_evt", k), evt_latch, tbl[k].evt);
    end

    // Two-cycle low glitch while accepted high must not produce fall.
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00001, 5'b00000);
    fall_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 5'b00000, 5'b00000);
      fall_cnt += int'(fall[0]);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 5'b00001, 5'b00000);
      fall_cnt += int'(fall[0]);
    end
    check_int("glitch_no_fall", fall_cnt, 0);
    check("glitch_level_held", level & 5'b00001, 5'b00001);

    // evt_clr coinciding with a new rise: set wins; a lone clear then takes effect.
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00000, 5'b00000);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step(1'b0, 5'b00001, 5'b00000);
      if (rise[0]) found = 1;
    end
    check_int("rerise_seen", found, 1);
    step(1'b0, 5'b00001, 5'b00001);
    check("clr_vs_rise_set_wins", evt_latch & 5'b00001, 5'b00001);
    step(1'b0, 5'b00001, 5'b00001);
    check("clr_alone", evt_latch & 5'b00001, 5'b00000);
    step(1'b0, 5'b00001, 5'b00000);
    check("clr_stays", evt_latch & 5'b00001, 5'b00000);

    // All channels high, reset pulsed mid-check, then hold through the long-press window.
    for (int k = 0; k < 3; k++) step(1'b0, 5'b11111, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 5'b11111, 5'b00000);
      check("in_reset_zero", level | rise | fall | evt_latch | long_press, 5'b00000);
    end
    first_rise = -1; rise_val = '0; long_cnt = 0; long_first = -1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 5'b11111, 5'b00000);
      if (rise != '0 && first_rise < 0) begin
        first_rise = k;
        rise_val   = rise;
      end
      if (long_press[2]) begin
        long_cnt++;
        if (long_first < 0) long_first = k;
      end
    end
    check_int("post_reset_rise_edge", first_rise, int'(D) + 2);
    check("post_reset_rise_all", rise_val, 5'b11111);
`ifdef BTN_LONG_PRESS_EN
    check_int("long_press_count", long_cnt, 1);
    check_int("long_press_edge", long_first, int'(D) + 2 + int'(L));
`else
    check_int("long_press_count", long_cnt, 0);
`endif

    // Randomized activity on all channels, with occasional clears and resets.
    din_r = 5'b11111;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 7) == 0) din_r[i] = ~din_r[i];
        clr_r[i] = ($urandom_range(0, 3) == 0);
      end
      rst_r = ($urandom_range(0, 199) == 0);
      step(rst_r, din_r, clr_r);
    end
    // Long steady high so long-press behaviour is exercised on every channel.
    for (int k = 0; k < 25; k++) step(1'b0, 5'b10101, 5'b00000);
    for (int k = 0; k < 25; k++) step(1'b0, 5'b01010, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
